// File: rtl/if_id_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_id_fetch_queue
//
// First-word-fall-through instruction queue between the IF stage and the ID
// stage. IF offers {instruction, pc+4} pairs. The oldest buffered pair is
// presented combinationally to ID. The queue lets IF keep fetching while ID is
// stalled on a hazard, until every entry is occupied. A taken branch (i_flush)
// discards every buffered entry, so wrong-path instructions never reach ID.
//
// Parameters
//   DEPTH  number of entries (power of two, >= 2)
//   WIDTH  instruction / pc width in bits
//
// Ports
//   i_clk             clock; all state updates on the rising edge
//   i_rst_n           asynchronous active-low reset
//   i_if_instruction  instruction word from IF
//   i_if_pc           pc+4 value from IF
//   i_if_valid        IF offers an entry this cycle
//   o_if_ready        queue accepts an entry this cycle; IF freezes its pc when 0
//   i_flush           branch taken: drop all entries at the next edge
//   i_id_stall        ID hazard: do not consume the head this cycle
//   o_id_instruction  head instruction, 0 (NOP) when empty
//   o_id_pc           head pc+4, 0 when empty
//   o_id_valid        head entry is valid
//   o_count           number of occupied entries
// -----------------------------------------------------------------------------
module if_id_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [WIDTH-1:0]           i_if_instruction,
    input  logic [WIDTH-1:0]           i_if_pc,
    input  logic                       i_if_valid,
    output logic                       o_if_ready,
    input  logic                       i_flush,
    input  logic                       i_id_stall,
    output logic [WIDTH-1:0]           o_id_instruction,
    output logic [WIDTH-1:0]           o_id_pc,
    output logic                       o_id_valid,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // Storage. No reset: an entry is only ever read while it is counted as
    // occupied, and every occupied slot was written by a push first.
    logic [WIDTH-1:0] r_mem_instr [DEPTH];
    logic [WIDTH-1:0] r_mem_pc    [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] r_wr_ptr_next;
    logic [PTR_W-1:0] r_rd_ptr_next;
    logic [CNT_W-1:0] r_count_next;

    logic             w_if_ready;
    logic             w_id_valid;
    logic             w_push;
    logic             w_pop;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // Full and empty come from the count register alone. As a result,
    // o_if_ready has no combinational path from i_id_stall. A full queue
    // refuses a push even in a cycle where it also pops.
    assign w_if_ready = (r_count != CNT_FULL);
    assign w_id_valid = (r_count != CNT_ZERO);

    // Flush overrides both directions, so the cycle in which a branch
    // resolves can neither admit a wrong-path word nor retire the head.
    assign w_push = i_if_valid & w_if_ready & ~i_flush;
    assign w_pop  = w_id_valid & ~i_id_stall & ~i_flush;

    // ------------------------------------------------------------------
    // Next-state computation for pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        r_wr_ptr_next = r_wr_ptr;
        r_rd_ptr_next = r_rd_ptr;
        r_count_next  = r_count;

        if (i_flush) begin
            // Realign both pointers to slot 0 so that post-flush behaviour
            // matches the behaviour after a reset.
            r_wr_ptr_next = '0;
            r_rd_ptr_next = '0;
            r_count_next  = '0;
        end else begin
            if (w_push) begin
                r_wr_ptr_next = r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr_next = r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count_next = r_count + CNT_W'(1);
                2'b01:   r_count_next = r_count - CNT_W'(1);
                default: r_count_next = r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control state registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr_next;
            r_rd_ptr <= r_rd_ptr_next;
            r_count  <= r_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage write
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= i_if_instruction;
            r_mem_pc[r_wr_ptr]    <= i_if_pc;
        end
    end

    // ------------------------------------------------------------------
    // Head presentation (first-word fall-through)
    // ------------------------------------------------------------------
    // The head is read combinationally, so an entry pushed into an empty
    // queue is visible right after the edge that wrote it. When the queue
    // is empty, the outputs are gated to zero so that ID sees a clean NOP
    // and not stale storage. This also holds during reset.
    assign o_id_valid       = w_id_valid;
    assign o_id_instruction = w_id_valid ? r_mem_instr[r_rd_ptr] : '0;
    assign o_id_pc          = w_id_valid ? r_mem_pc[r_rd_ptr]    : '0;
    assign o_if_ready       = w_if_ready;
    assign o_count          = r_count;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
module tb_if_id_fetch_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] i_if_instruction;
    logic [WIDTH-1:0] i_if_pc;
    logic             i_if_valid;
    logic             o_if_ready;
    logic             i_flush;
    logic             i_id_stall;
    logic [WIDTH-1:0] o_id_instruction;
    logic [WIDTH-1:0] o_id_pc;
    logic             o_id_valid;
    logic [2:0]       o_count;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: {instruction, pc} in expected pop order
    logic [63:0] sb[$];
    int          m_count = 0;

    if_id_fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_if_instruction (i_if_instruction),
        .i_if_pc          (i_if_pc),
        .i_if_valid       (i_if_valid),
        .o_if_ready       (o_if_ready),
        .i_flush          (i_flush),
        .i_id_stall       (i_id_stall),
        .o_id_instruction (o_id_instruction),
        .o_id_pc          (o_id_pc),
        .o_id_valid       (o_id_valid),
        .o_count          (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the visible state of the DUT against the model. This is done
    // just before the rising edge, with the inputs already driven.
    task automatic check_state(input string tag);
        chk({tag, "_if_ready"}, 64'(o_if_ready), 64'(m_count != DEPTH));
        chk({tag, "_id_valid"}, 64'(o_id_valid), 64'(m_count != 0));
        chk({tag, "_count"}, 64'(o_count), 64'(m_count));
        if (m_count != 0) begin
            chk({tag, "_head"}, {o_id_instruction, o_id_pc}, sb[0]);
        end else begin
            chk({tag, "_nop"}, {o_id_instruction, o_id_pc}, 64'h0);
        end
    endtask

    // One clock cycle: drive inputs, check the state before the edge, then
    // update the scoreboard after the edge.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit st, input bit fl, output bit acc);
        bit pop;
        @(negedge clk);
        i_if_valid = v;
        i_if_instruction = ins;
        i_if_pc = pc;
        i_id_stall = st;
        i_flush = fl;
        #1;
        check_state("pre");
        acc = v && (m_count != DEPTH) && !fl;
        pop = (m_count != 0) && !st && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
            m_count = 0;
        end else begin
            if (pop) begin
                $display("pop  ins=%08h pc=%08h", sb[0][63:32], sb[0][31:0]);
                void'(sb.pop_front());
                m_count--;
            end
            if (acc) begin
                $display("push ins=%08h pc=%08h", ins, pc);
                sb.push_back({ins, pc});
                m_count++;
            end
        end
    endtask

    task automatic drain();
        bit a;
        int guard = 0;
        while (m_count != 0 && guard < 50) begin
            step(0, 0, 0, 0, 0, a);
            guard++;
        end
        chk("drain_done", 64'(m_count), 64'd0);
    endtask

    initial begin
        bit a;
        int k;
        int guard;

        rst_n = 1'b0;
        i_if_valid = 1'b1;
        i_if_instruction = 32'h99;
        i_if_pc = 32'h4;
        i_flush = 1'b0;
        i_id_stall = 1'b0;

        // Reset held while IF offers: nothing may be captured
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_id_valid", 64'(o_id_valid), 64'd0);
        chk("rst_id_instr", 64'(o_id_instruction), 64'd0);
        chk("rst_id_pc", 64'(o_id_pc), 64'd0);
        chk("rst_if_ready", 64'(o_if_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        i_if_valid = 1'b0;

        // Stream: with no stall, each entry is visible for one cycle
        step(1, 32'h11, 32'd4, 0, 0, a);
        chk("stream_cnt_le1", 64'(o_count <= 1), 64'd1);
        step(1, 32'h22, 32'd8, 0, 0, a);
        chk("stream_cnt_le1", 64'(o_count <= 1), 64'd1);
        step(1, 32'h33, 32'd12, 0, 0, a);
        chk("stream_cnt_le1", 64'(o_count <= 1), 64'd1);
        drain();

        // Fill under stall: the 5th entry is refused and held by IF
        for (k = 1; k <= 4; k++) begin
            step(1, 32'h100 + 32'(k), 32'(4 * k), 1, 0, a);
            chk("fill_acc", 64'(a), 64'd1);
        end
        step(1, 32'h105, 32'd20, 1, 0, a);
        chk("fill_5th_refused", 64'(o_if_ready), 64'd0);
        guard = 0;
        a = 0;
        while (!a && guard < 20) begin
            step(1, 32'h105, 32'd20, 0, 0, a);
            guard++;
        end
        chk("fill_5th_accepted", 64'(a), 64'd1);
        drain();

        // Wrap: 10 entries with intermittent stalls
        k = 0;
        guard = 0;
        while (k < 10 && guard < 200) begin
            step(1, 32'h200 + 32'(k), 32'(4 * (k + 1)), ($urandom_range(0, 2) == 0), 0, a);
            if (a) k++;
            guard++;
        end
        chk("wrap_all_pushed", 64'(k), 64'd10);
        drain();

        // Flush with count=3 while IF offers and ID does not stall
        for (k = 0; k < 3; k++) step(1, 32'h300 + 32'(k), 32'(4 * k), 1, 0, a);
        chk("flush_pre_count", 64'(o_count), 64'd3);
        step(1, 32'h3FF, 32'h40, 0, 1, a);
        chk("flush_count", 64'(o_count), 64'd0);
        chk("flush_id_valid", 64'(o_id_valid), 64'd0);
        chk("flush_id_instr", 64'(o_id_instruction), 64'd0);
        chk("flush_if_ready", 64'(o_if_ready), 64'd1);
        step(1, 32'hAA, 32'h44, 1, 0, a);
        chk("flush_new_head", 64'(o_id_instruction), 64'hAA);
        drain();

        // Flush while full
        for (k = 0; k < 4; k++) step(1, 32'h400 + 32'(k), 32'(4 * k), 1, 0, a);
        step(1, 32'h4FF, 32'h0, 1, 1, a);
        chk("flush_full_count", 64'(o_count), 64'd0);
        step(1, 32'h4AB, 32'h50, 0, 0, a);
        drain();

        // Async reset between edges with count=2
        step(1, 32'h501, 32'd4, 1, 0, a);
        step(1, 32'h502, 32'd8, 1, 0, a);
        chk("arst_pre_count", 64'(o_count), 64'd2);
        i_if_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(o_count), 64'd0);
        chk("arst_id_valid", 64'(o_id_valid), 64'd0);
        chk("arst_id_instr", 64'(o_id_instruction), 64'd0);
        chk("arst_if_ready", 64'(o_if_ready), 64'd1);
        sb.delete();
        m_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, a);
        step(1, 32'h600, 32'd4, 0, 0, a);
        step(0, 0, 0, 0, 0, a);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
